// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel/sync bundle between vga_timing and the image generator/DAC side
interface vga_timing_if;
  logic [2:0]  color_in;
  logic [11:0] x;
  logic [11:0] y;
  logic        hsync;
  logic        vsync;
  logic        video_active;
  logic        frame_start;
  logic [2:0]  rgb;

  // timing generator side: takes colour back, drives coordinates, syncs and DAC colour
  modport master (
    input  color_in,
    output x, y, hsync, vsync, video_active, frame_start, rgb
  );

  // consumer side: image generator / DAC / monitor
  modport slave (
    output color_in,
    input  x, y, hsync, vsync, video_active, frame_start, rgb
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator (x/y, syncs, blanking); optional VGA_PIPE_EN adds a registered colour stage
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          CLOCK_25,
  input  logic          RESET,
  vga_timing_if.master  vga
);

  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_active;
  logic        r_frame_start;

  logic [11:0] w_x_nxt;
  logic [11:0] w_y_nxt;
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_active_nxt;
  logic        w_fs_nxt;

  // next counter values; x wraps at end of line, y advances on x wrap and wraps at end of frame
  always_comb begin
    w_x_nxt = r_x + 12'd1;
    w_y_nxt = r_y;
    if (r_x == H_LAST) begin
      w_x_nxt = 12'd0;
      if (r_y == V_LAST) begin
        w_y_nxt = 12'd0;
      end else begin
        w_y_nxt = r_y + 12'd1;
      end
    end
  end

  // decode from next counters so the registered flags line up with the x/y they describe
  always_comb begin
    w_hs_on      = (w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST);
    w_vs_on      = (w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST);
    w_active_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    w_fs_nxt     = (w_x_nxt == 12'd0) && (w_y_nxt == 12'd0);
  end

  // counters and aligned flags; reset parks counters on the last pixel so the first edge lands on (0,0)
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_active      <= w_active_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

  assign vga.x = r_x;
  assign vga.y = r_y;

`ifdef VGA_PIPE_EN
  logic       r_p_hsync;
  logic       r_p_vsync;
  logic       r_p_active;
  logic       r_p_frame_start;
  logic [2:0] r_p_rgb;

  // output stage: registered blanked colour, with the flags delayed to stay aligned with it
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_p_hsync       <= ~SYNC_POL;
      r_p_vsync       <= ~SYNC_POL;
      r_p_active      <= 1'b0;
      r_p_frame_start <= 1'b0;
      r_p_rgb         <= 3'b000;
    end else begin
      r_p_hsync       <= r_hsync;
      r_p_vsync       <= r_vsync;
      r_p_active      <= r_active;
      r_p_frame_start <= r_frame_start;
      r_p_rgb         <= r_active ? vga.color_in : 3'b000;
    end
  end

  assign vga.hsync        = r_p_hsync;
  assign vga.vsync        = r_p_vsync;
  assign vga.video_active = r_p_active;
  assign vga.frame_start  = r_p_frame_start;
  assign vga.rgb          = r_p_rgb;
`else
  assign vga.hsync        = r_hsync;
  assign vga.vsync        = r_vsync;
  assign vga.video_active = r_active;
  assign vga.frame_start  = r_frame_start;
  // colour comes back combinationally from x/y, so blanking here keeps it aligned
  assign vga.rgb          = r_active ? vga.color_in : 3'b000;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing (reduced and default geometries)
module tb_vga_timing;

`ifdef VGA_PIPE_EN
  localparam int PD = 1;
`else
  localparam int PD = 0;
`endif

  localparam int S_HA = 64, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VA = 48, S_VF = 3, S_VS = 2, S_VB = 5;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [2:0]  rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] const_color;
  logic       pattern_en;
  logic       cmp_en = 1'b0;
  logic       count_en = 1'b1;
  int         cyc = -1;
  int         checks = 0;
  int         errors = 0;

  int b_hs_low = 0;
  int b_hs_first = -1;
  int b_inact_first = -1;
  int s_vs_low = 0;
  int s_fs_cnt = 0;

  vga_timing_if s_if ();
  vga_timing_if b_if ();

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b0)
  ) u_small (
    .CLOCK_25(clk),
    .RESET(rst),
    .vga(s_if)
  );

  vga_timing u_big (
    .CLOCK_25(clk),
    .RESET(rst),
    .vga(b_if)
  );

  always #5 clk = ~clk;

  // image generator stand-in: colour is a pure function of the presented coordinates
  always_comb s_if.color_in = const_color ^ (pattern_en ? (s_if.x[2:0] ^ s_if.y[2:0]) : 3'b000);
  always_comb b_if.color_in = const_color ^ (pattern_en ? (b_if.x[2:0] ^ b_if.y[2:0]) : 3'b000);

  // clocks elapsed since reset release; -1 while in reset
  always @(posedge clk or posedge rst) begin
    if (rst) cyc = -1;
    else     cyc = cyc + 1;
  end

  function automatic exp_t base(int c, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    exp_t e;
    int ht, vt, xx, yy;
    logic [2:0] cc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (c < 0) begin
      e.x = 12'(ht - 1); e.y = 12'(vt - 1);
      e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.fs = 1'b0; e.rgb = 3'b000;
    end else begin
      xx = c % ht;
      yy = (c / ht) % vt;
      e.x   = 12'(xx);
      e.y   = 12'(yy);
      e.hs  = !(xx >= ha + hf && xx < ha + hf + hs);
      e.vs  = !(yy >= va + vf && yy < va + vf + vs);
      e.act = (xx < ha) && (yy < va);
      e.fs  = (xx == 0) && (yy == 0);
      cc    = const_color ^ (pattern_en ? (3'(xx) ^ 3'(yy)) : 3'b000);
      e.rgb = e.act ? cc : 3'b000;
    end
    return e;
  endfunction

  function automatic exp_t model_at(int c, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    exp_t e;
    e = base(c, ha, hf, hs, hb, va, vf, vs, vb);
`ifdef VGA_PIPE_EN
    begin
      exp_t p;
      p = base(c - 1, ha, hf, hs, hb, va, vf, vs, vb);
      e.hs = p.hs; e.vs = p.vs; e.act = p.act; e.fs = p.fs; e.rgb = p.rgb;
    end
`endif
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic cmp_small(exp_t e);
    check("s_x", 32'(s_if.x), 32'(e.x));
    check("s_y", 32'(s_if.y), 32'(e.y));
    check("s_hsync", 32'(s_if.hsync), 32'(e.hs));
    check("s_vsync", 32'(s_if.vsync), 32'(e.vs));
    check("s_active", 32'(s_if.video_active), 32'(e.act));
    check("s_fs", 32'(s_if.frame_start), 32'(e.fs));
    check("s_rgb", 32'(s_if.rgb), 32'(e.rgb));
  endtask

  task automatic cmp_big(exp_t e);
    check("b_x", 32'(b_if.x), 32'(e.x));
    check("b_y", 32'(b_if.y), 32'(e.y));
    check("b_hsync", 32'(b_if.hsync), 32'(e.hs));
    check("b_vsync", 32'(b_if.vsync), 32'(e.vs));
    check("b_active", 32'(b_if.video_active), 32'(e.act));
    check("b_fs", 32'(b_if.frame_start), 32'(e.fs));
    check("b_rgb", 32'(b_if.rgb), 32'(e.rgb));
  endtask

  // every-cycle comparison of both instances against the model, plus window statistics
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_small(model_at(cyc, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
      cmp_big(model_at(cyc, 640, 16, 96, 48, 480, 10, 2, 33));
      if (count_en && cyc >= 0 && cyc < 800) begin
        if (!b_if.hsync) begin
          b_hs_low++;
          if (b_hs_first < 0) b_hs_first = cyc;
        end
        if (cyc >= 2 && !b_if.video_active && b_inact_first < 0) b_inact_first = cyc;
      end
      if (count_en && cyc >= 0 && cyc < S_FRAME) begin
        if (!s_if.vsync) s_vs_low++;
        if (s_if.frame_start) s_fs_cnt++;
      end
    end
  end

  task automatic wait_cyc(int n);
    int g;
    g = 0;
    while (cyc != n && g < 100000) begin
      @(negedge clk);
      g++;
    end
    check("wait_cyc", 32'(cyc), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    pattern_en = 1'b1;
    const_color = 3'b000;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_b_x", 32'(b_if.x), 32'd799);
    check("rst_b_y", 32'(b_if.y), 32'd524);
    check("rst_b_hs", 32'(b_if.hsync), 32'd1);
    check("rst_b_act", 32'(b_if.video_active), 32'd0);
    check("rst_s_x", 32'(s_if.x), 32'd79);
    check("rst_s_y", 32'(s_if.y), 32'd57);
    @(negedge clk);
    rst = 1'b0;

    @(posedge clk); #1;
    check("rel_x", 32'(b_if.x), 32'd0);
    check("rel_y", 32'(b_if.y), 32'd0);
    check("rel_fs", 32'(b_if.frame_start), 32'(PD == 0));
    check("rel_act", 32'(b_if.video_active), 32'(PD == 0));
    check("rel_hs", 32'(b_if.hsync), 32'd1);
    check("rel_vs", 32'(b_if.vsync), 32'd1);
    @(posedge clk); #1;
    check("rel_fs2", 32'(b_if.frame_start), 32'(PD == 1));

    wait_cyc(799);
    check("wrap_x0", 32'(b_if.x), 32'd799);
    check("wrap_y0", 32'(b_if.y), 32'd0);
    @(negedge clk);
    check("wrap_x1", 32'(b_if.x), 32'd0);
    check("wrap_y1", 32'(b_if.y), 32'd1);
    check("b_hs_low_cnt", 32'(b_hs_low), 32'd96);
    check("b_hs_first", 32'(b_hs_first), 32'(656 + PD));
    check("b_act_drop", 32'(b_inact_first), 32'(640 + PD));

    wait_cyc(S_FRAME);
    check("s_frame_x", 32'(s_if.x), 32'd0);
    check("s_frame_y", 32'(s_if.y), 32'd0);
    check("s_vs_low_cnt", 32'(s_vs_low), 32'd160);
    check("s_fs_cnt", 32'(s_fs_cnt), 32'd1);
    count_en = 1'b0;

    wait_cyc(S_FRAME + 20 * 80 + 30);
    check("pre_rst_rgb", 32'(s_if.rgb), 32'(PD == 0 ? 3'd2 : 3'd1));
    #2 rst = 1'b1;
    #1;
    check("mid_s_x", 32'(s_if.x), 32'd79);
    check("mid_s_y", 32'(s_if.y), 32'd57);
    check("mid_s_rgb", 32'(s_if.rgb), 32'd0);
    check("mid_s_act", 32'(s_if.video_active), 32'd0);
    check("mid_b_x", 32'(b_if.x), 32'd799);
    check("mid_b_y", 32'(b_if.y), 32'd524);
    check("mid_b_rgb", 32'(b_if.rgb), 32'd0);
    pattern_en = 1'b0;
    const_color = 3'b101;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    @(posedge clk); #1;
    check("restart_x", 32'(s_if.x), 32'd0);
    check("restart_y", 32'(s_if.y), 32'd0);
    check("restart_rgb", 32'(s_if.rgb), 32'(PD == 0 ? 3'b101 : 3'b000));
    @(posedge clk); #1;
    check("restart_rgb2", 32'(s_if.rgb), 32'd5);

    wait_cyc(47 * 80 + 63 + PD);
    check("rgb_last_vis", 32'(s_if.rgb), 32'd5);
    @(negedge clk);
    check("rgb_h_blank", 32'(s_if.rgb), 32'd0);
    wait_cyc(48 * 80 + PD);
    check("rgb_v_blank", 32'(s_if.rgb), 32'd0);

    wait_cyc(S_FRAME + 100);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
